pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Measures an incoming PWM waveform and reports its high time and period in the same 16-bit {duty, period} word format that PWM_Driver accepts on its data input. It is the reading end of the PWM path: loopback self-test of PWM_Driver, and measuring external PWM sources such as RC receivers and fan tach-PWM. A sys_clk-domain state machine synchronises the pin, detects edges, counts ticks and publishes one measurement per input period with a valid strobe.

Parameters:
PRESCALE, 1, sys_clk cycles per count tick (>=1); counts are in ticks.
TIMEOUT_TICKS, 512, ticks without a rising edge before a stuck-level result is published.
CNT_W, 8, width of the duty and period fields.

Ports:
sys_clk  input  1  system clock; only clock.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = measure; 0 = return to IDLE and hold the last result.
signal_in  input  1  PWM input; asynchronous to sys_clk.
data  output  2*CNT_W  {duty, period}; duty in [15:8], period in [7:0].
valid  output  1  one-cycle pulse when data is updated.
overflow  output  1  sticky; a count saturated in the last published result.
stuck  output  1  the last result came from a timeout.

Behaviour:
- Reset is async and active-high. data=0, valid=0, overflow=0, stuck=0, state=IDLE, synchroniser flops=0, counters=0.
- Synchroniser: two flops on signal_in, then one history flop. A rising edge is sync=1 & prev=0. Pin-to-edge-detect latency is 3 sys_clk cycles.
- Tick generator: a tick pulses once every PRESCALE cycles. It is free-running while enable=1 and cleared when enable=0. With PRESCALE=1 the tick is always 1.
- States:
  - IDLE: wait for a rising edge, then clear the counters and go to HIGH.
  - HIGH: on each tick, increment high_cnt and per_cnt. On a falling edge go to LOW.
  - LOW: on each tick, increment per_cnt. On a rising edge, publish and go to HIGH.
- Counting and publishing:
  - The cycle containing the closing rising edge is counted in the new period, not the old one.
  - Publish: data <= {high_cnt, per_cnt}; valid=1 on the next cycle; overflow <= saturation seen; stuck <= 0. Counters restart at 0 in the same cycle as the edge, so back-to-back periods have no gap.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- Timeout: idle_cnt counts ticks since the last rising edge, in all states except IDLE-before-first-edge. When it reaches TIMEOUT_TICKS:
  - sync=1: publish {FF,FF} with stuck=1.
  - sync=0: publish {00,00} with stuck=1.
  - Then go to IDLE. Only one publish per stuck event; the next rising edge restarts measurement.
- The first rising edge after reset or after enable rises does not publish; the first result arrives at the second rising edge.
- Glitches shorter than 1 sys_clk may be missed. No further filtering is applied.
- enable falling mid-measurement: the partial result is discarded and data/overflow/stuck are held. valid is never asserted while enable=0.
- A rising edge and timeout in the same cycle: the edge wins (normal publish, idle_cnt cleared).
- Async reset mid-period: everything clears immediately; no valid is emitted.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum (IDLE, HIGH, LOW);
  - DUTY_MSB/DUTY_LSB/PERIOD_MSB/PERIOD_LSB field constants, shared with PWM_Driver;
  - the default CNT_W.
- One sub-module: pwm_edge_sync, containing the 2-flop synchroniser, the history flop and rise/fall outputs.
- Tick generator and FSM stay inline.

Test Plan:
- Loopback with PWM_Driver, PRESCALE=1: wire the driver's signal output to signal_in and load data={8'd64, 8'd128}. Each valid must show data=16'h4080 (duty 64, period 128), overflow=0, stuck=0, every 128 cycles after the first result.
- Square input, high 3 / low 5 cycles: the second rising edge gives valid with data={8'd3, 8'd8}. Subsequent valids are spaced exactly 8 cycles apart.
- Long period, high 100 / low 300 cycles: data={8'd100, 8'hFF}, overflow=1. A following 10/20 input clears overflow on its next publish.
- Stuck high: hold signal_in=1 after one rising edge. After 512 ticks, one valid with data=16'hFFFF, stuck=1, and no further valids. Stuck low gives 16'h0000, stuck=1.
- PRESCALE=4, high 8 / low 8 cycles: data={8'd2, 8'd4}.
- enable dropped mid-HIGH, or reset asserted mid-LOW: no valid. Outputs hold (enable) or clear to 0 (reset). After re-enable, the first publish comes at the second rising edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM path: capture FSM states and the {duty, period}
// word layout that the driver and the capture block agree on.
package pwm_pkg;

  localparam int DEF_CNT_W  = 8;

  // Field positions of the 16-bit {duty, period} word.
  localparam int DUTY_MSB   = 2 * DEF_CNT_W - 1;
  localparam int DUTY_LSB   = DEF_CNT_W;
  localparam int PERIOD_MSB = DEF_CNT_W - 1;
  localparam int PERIOD_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin, followed by a history flop
// that turns level changes into single-cycle rise/fall strobes.
module pwm_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_sig;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in prescaled ticks
// and publishes one {duty, period} word per input period.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PRESCALE      = 1,
  parameter int TIMEOUT_TICKS = 512,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               signal_in,
  output logic [2*CNT_W-1:0] data,
  output logic               valid,
  output logic               overflow,
  output logic               stuck,
  output state_t             o_dbg_state
);

  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IDLE_W-1:0] TMO_LAST = IDLE_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_tick;

  pwm_edge_sync u_edge_sync (
    .i_clk  (sys_clk),
    .i_rst  (reset),
    .i_sig  (signal_in),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Tick generator: free-running while enabled, phase restarts on enable.
  generate
    if (PRESCALE <= 1) begin : g_no_prescale
      assign w_tick = enable;
    end else begin : g_prescale
      logic [PRE_W-1:0] r_pre_cnt;

      always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
          r_pre_cnt <= '0;
        end else if (!enable) begin
          r_pre_cnt <= '0;
        end else if (r_pre_cnt == PRE_W'(PRESCALE - 1)) begin
          r_pre_cnt <= '0;
        end else begin
          r_pre_cnt <= r_pre_cnt + 1'b1;
        end
      end

      assign w_tick = enable & (r_pre_cnt == PRE_W'(PRESCALE - 1));
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_high_cnt;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_sat;
  logic [2*CNT_W-1:0] r_data;
  logic              r_valid;
  logic              r_overflow;
  logic              r_stuck;

  logic             w_start;
  logic             w_pub;
  logic             w_tmo;
  logic             w_inc_high;
  logic             w_inc_per;
  logic             w_inc_idle;
  logic             w_tmo_hit;
  logic [CNT_W-1:0] w_start_val;

  assign w_tmo_hit   = w_tick & (r_idle_cnt == TMO_LAST);
  // The edge cycle already belongs to the new period, so it seeds the counts.
  assign w_start_val = {{(CNT_W-1){1'b0}}, w_tick};

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_pub       = 1'b0;
    w_tmo       = 1'b0;
    w_inc_high  = 1'b0;
    w_inc_per   = 1'b0;
    w_inc_idle  = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_start     = 1'b1;
            w_state_nxt = HIGH;
          end
        end
        HIGH, LOW: begin
          // A closing edge outranks a timeout landing in the same cycle.
          if (w_rise) begin
            w_pub       = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = HIGH;
          end else if (w_tmo_hit) begin
            w_tmo       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_inc_per  = w_tick;
            w_inc_idle = w_tick;
            if (r_state == HIGH) begin
              if (w_fall) begin
                w_state_nxt = LOW;
              end else begin
                w_inc_high = w_tick;
              end
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      r_idle_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_start) begin
      r_high_cnt <= w_start_val;
      r_per_cnt  <= w_start_val;
      r_idle_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      if (w_inc_high) begin
        if (r_high_cnt == CNT_MAX) begin
          r_sat <= 1'b1;
        end else begin
          r_high_cnt <= r_high_cnt + 1'b1;
        end
      end
      if (w_inc_per) begin
        if (r_per_cnt == CNT_MAX) begin
          r_sat <= 1'b1;
        end else begin
          r_per_cnt <= r_per_cnt + 1'b1;
        end
      end
      if (w_tmo) begin
        r_idle_cnt <= '0;
      end else if (w_inc_idle) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  // valid is a one-cycle strobe with no back-pressure: data/overflow/stuck
  // change only in the cycle valid is high and hold otherwise.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_pub) begin
        r_data     <= {r_high_cnt, r_per_cnt};
        r_valid    <= 1'b1;
        r_overflow <= r_sat;
        r_stuck    <= 1'b0;
      end else if (w_tmo) begin
        r_data     <= {(2*CNT_W){w_sync}};
        r_valid    <= 1'b1;
        r_overflow <= 1'b0;
        r_stuck    <= 1'b1;
      end
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign overflow    = r_overflow;
  assign stuck       = r_stuck;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: table of square-wave vectors, hand-written corner
// sequences, and a randomized run scored against an arithmetic period model.
module tb_pwm_capture;
  import pwm_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        en4 = 1'b0;
  logic        sig = 1'b0;
  logic [15:0] data1, data4;
  logic        valid1, valid4, ovf1, ovf4, stk1, stk4;
  state_t      st1, st4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    logic        stk;
    int          t;
  } obs_t;

  typedef struct {
    int          h;
    int          l;
    int          n;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  obs_t        obs_q[$];
  obs_t        obs4_q[$];
  logic [16:0] exp_q[$];
  int          exp_gap_q[$];
  vec_t        vecs[8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture #(.PRESCALE(1), .TIMEOUT_TICKS(512), .CNT_W(8)) dut1 (
    .sys_clk(clk), .reset(rst), .enable(en), .signal_in(sig),
    .data(data1), .valid(valid1), .overflow(ovf1), .stuck(stk1),
    .o_dbg_state(st1)
  );

  pwm_capture #(.PRESCALE(4), .TIMEOUT_TICKS(512), .CNT_W(8)) dut4 (
    .sys_clk(clk), .reset(rst), .enable(en4), .signal_in(sig),
    .data(data4), .valid(valid4), .overflow(ovf4), .stuck(stk4),
    .o_dbg_state(st4)
  );

  // ---------------- monitor ----------------
  logic v1_d = 1'b0;
  logic v4_d = 1'b0;

  always @(negedge clk) begin
    obs_t o;
    if (valid1) begin
      o.data = data1; o.ovf = ovf1; o.stk = stk1; o.t = cyc;
      obs_q.push_back(o);
      checks++;
      if (!en || v1_d) begin
        errors++;
        $display("FAIL valid1_strobe en=%0b prev_valid=%0b required en=1 prev_valid=0", en, v1_d);
      end
    end
    if (valid4) begin
      o.data = data4; o.ovf = ovf4; o.stk = stk4; o.t = cyc;
      obs4_q.push_back(o);
      checks++;
      if (!en4 || v4_d) begin
        errors++;
        $display("FAIL valid4_strobe en=%0b prev_valid=%0b required en=1 prev_valid=0", en4, v4_d);
      end
    end
    v1_d = valid1;
    v4_d = valid4;
  end

  // ---------------- helpers / model ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period(input int h, input int l);
    sig = 1'b1; step(h);
    sig = 1'b0; step(l);
  endtask

  task automatic rise_end();
    sig = 1'b1; step(6);
  endtask

  task automatic restart();
    en = 1'b0; en4 = 1'b0; sig = 1'b0;
    step(4);
    obs_q.delete(); obs4_q.delete();
    en = 1'b1;
    step(4);
  endtask

  // Expected {overflow, duty, period} for a period of h high and l low cycles.
  function automatic logic [16:0] ref_word(input int h, input int l);
    int hs, ps;
    hs = (h > 255) ? 255 : h;
    ps = (h + l > 255) ? 255 : h + l;
    return {((h + l) > 255), 8'(hs), 8'(ps)};
  endfunction

  // ---------------- test ----------------
  initial begin : main
    int t0;
    vecs[0] = '{3,   5,   4, 16'h0308, 1'b0};
    vecs[1] = '{64,  64,  4, 16'h4080, 1'b0};
    vecs[2] = '{100, 300, 2, 16'h64FF, 1'b1};
    vecs[3] = '{10,  20,  3, 16'h0A1E, 1'b0};
    vecs[4] = '{1,   1,   4, 16'h0102, 1'b0};
    vecs[5] = '{200, 55,  2, 16'hC8FF, 1'b0};
    vecs[6] = '{200, 56,  2, 16'hC8FF, 1'b1};
    vecs[7] = '{300, 10,  2, 16'hFFFF, 1'b1};

    step(3);
    check("rst_data1", data1, 16'h0000);
    check("rst_data4", data4, 16'h0000);
    check("rst_flags1", {valid1, ovf1, stk1}, 3'b000);
    check("rst_state1", st1, IDLE);
    rst = 1'b0;
    step(2);

    // Table-driven square waves.
    for (int i = 0; i < 8; i++) begin
      restart();
      for (int p = 0; p < vecs[i].n; p++) period(vecs[i].h, vecs[i].l);
      rise_end();
      check($sformatf("vec%0d_count", i), obs_q.size(), vecs[i].n);
      for (int k = 0; k < obs_q.size(); k++) begin
        check($sformatf("vec%0d_data%0d", i, k), obs_q[k].data, vecs[i].exp_data);
        check($sformatf("vec%0d_ovf%0d", i, k), obs_q[k].ovf, vecs[i].exp_ovf);
        check($sformatf("vec%0d_stk%0d", i, k), obs_q[k].stk, 1'b0);
        if (k > 0)
          check($sformatf("vec%0d_gap%0d", i, k), obs_q[k].t - obs_q[k-1].t, vecs[i].h + vecs[i].l);
      end
    end

    // Saturated period followed by a short one clears overflow.
    restart();
    period(100, 300); period(10, 20); period(10, 20); rise_end();
    check("ovfseq_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("ovfseq_0", {obs_q[0].ovf, obs_q[0].data}, {1'b1, 16'h64FF});
      check("ovfseq_1", {obs_q[1].ovf, obs_q[1].data}, {1'b0, 16'h0A1E});
      check("ovfseq_2", {obs_q[2].ovf, obs_q[2].data}, {1'b0, 16'h0A1E});
    end
    check("ovfseq_out", ovf1, 1'b0);

    // Randomized back-to-back periods against the arithmetic model.
    restart();
    exp_q.delete(); exp_gap_q.delete();
    for (int k = 0; k < 30; k++) begin
      int h, l;
      h = $urandom_range(1, 60);
      l = ($urandom_range(0, 4) == 0) ? $urandom_range(150, 250) : $urandom_range(1, 60);
      period(h, l);
      exp_q.push_back(ref_word(h, l));
      exp_gap_q.push_back(h + l);
    end
    rise_end();
    check("rand_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < obs_q.size() && k < exp_gap_q.size(); k++) begin
      check($sformatf("rand_word%0d", k), {obs_q[k].ovf, obs_q[k].data}, exp_q[k]);
      check($sformatf("rand_stk%0d", k), obs_q[k].stk, 1'b0);
      if (k > 0) check($sformatf("rand_gap%0d", k), obs_q[k].t - obs_q[k-1].t, exp_gap_q[k]);
    end

    // Stuck high after one rising edge.
    restart();
    sig = 1'b1; t0 = cyc;
    step(1300);
    check("stuckhi_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      check("stuckhi_data", obs_q[0].data, 16'hFFFF);
      check("stuckhi_stk", obs_q[0].stk, 1'b1);
      check("stuckhi_time_ok", (obs_q[0].t - t0 >= 505) && (obs_q[0].t - t0 <= 525), 1'b1);
    end
    check("stuckhi_state", st1, IDLE);

    // Stuck low after one pulse.
    obs_q.delete();
    sig = 1'b0; step(5);
    sig = 1'b1; t0 = cyc; step(5);
    sig = 1'b0; step(1300);
    check("stucklo_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      check("stucklo_data", obs_q[0].data, 16'h0000);
      check("stucklo_stk", obs_q[0].stk, 1'b1);
      check("stucklo_time_ok", (obs_q[0].t - t0 >= 505) && (obs_q[0].t - t0 <= 525), 1'b1);
    end
    check("stucklo_out", stk1, 1'b1);

    // Prescaled instance: 8/8 cycles at 4 cycles per tick.
    en = 1'b0; en4 = 1'b0; sig = 1'b0; step(4);
    obs_q.delete(); obs4_q.delete();
    en4 = 1'b1; step(3);
    for (int p = 0; p < 4; p++) period(8, 8);
    rise_end();
    check("p4_count", obs4_q.size(), 4);
    for (int k = 0; k < obs4_q.size(); k++) begin
      check($sformatf("p4_data%0d", k), obs4_q[k].data, 16'h0204);
      if (k > 0) check($sformatf("p4_gap%0d", k), obs4_q[k].t - obs4_q[k-1].t, 16);
    end
    en4 = 1'b0;

    // Enable dropped mid-HIGH: nothing published, outputs hold.
    restart();
    period(3, 5); sig = 1'b1; step(6);
    en = 1'b0; step(2);
    check("endrop_state", st1, IDLE);
    sig = 1'b0; step(10);
    sig = 1'b1; step(5);
    sig = 1'b0; step(5);
    check("endrop_count", obs_q.size(), 1);
    check("endrop_hold", {stk1, ovf1, data1}, {2'b00, 16'h0308});
    en = 1'b1; step(2);
    period(6, 6);
    check("reen_first_edge", obs_q.size(), 1);
    rise_end();
    check("reen_count", obs_q.size(), 2);
    if (obs_q.size() == 2) check("reen_data", obs_q[1].data, 16'h060C);

    // Reset asserted mid-LOW.
    restart();
    period(5, 5); sig = 1'b1; step(4);
    sig = 1'b0; step(3);
    rst = 1'b1; #2;
    check("rstmid_data", data1, 16'h0000);
    check("rstmid_flags", {valid1, ovf1, stk1}, 3'b000);
    check("rstmid_state", st1, IDLE);
    step(2);
    rst = 1'b0; step(10);
    check("rstmid_novalid", obs_q.size(), 1);
    period(5, 5);
    check("rstmid_first_edge", obs_q.size(), 1);
    rise_end();
    check("rstmid_count", obs_q.size(), 2);
    if (obs_q.size() == 2) check("rstmid_data2", obs_q[1].data, 16'h050A);

    sig = 1'b0; en = 1'b0; step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
